memory_port_arbiter: RTL

Arbitrates the single-port unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the pipelined MIPS core. Each access occupies a configurable number of wait states. While a requester waits, the block raises stall signals that freeze the PC, IF/ID and, for data accesses, the whole pipeline. It sits beside the hazard detection unit; its stalls are OR-ed into the same enables.

---
 rtl/memory_arbiter_pkg.sv | 20 ++
 rtl/wait_state_counter.sv | 31 +++
 rtl/memory_port_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: FSM states, grant IDs and counter sizing.
// Latency: none; this file holds declarations only.
// Backpressure: none; this file holds declarations only.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        DATA  = 2'b10
    } arb_state_t;

    localparam logic GNT_FETCH = 1'b0;
    localparam logic GNT_DATA  = 1'b1;

    // Wait-state counter width; never narrower than one bit so WAIT_STATES=0 still builds.
    function automatic int cnt_width(input int wait_states);
        return (wait_states < 1) ? 1 : $clog2(wait_states + 1);
    endfunction

endpackage

// File: rtl/wait_state_counter.sv
// Down-counter that paces one RAM access: load with WAIT_STATES, count to zero, then hold at zero.
// Latency: a loaded value reaches zero after that many cycles; zero is combinational from the count.
// Backpressure: none; it is loaded only when the arbiter grants an access.
// Ports: clk/reset (async active-low), load + value in, count + zero flag out.
module wait_state_counter
    import memory_arbiter_pkg::*;
#(
    parameter  int WAIT_STATES = 2,
    localparam int CW          = cnt_width(WAIT_STATES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] value,
    output logic [CW-1:0] count,
    output logic          zero
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store, WAIT_STATES+1 cycles per access.
// Latency: grant seen in IDLE at cycle 0, ready in cycle WAIT_STATES+1, back to IDLE in WAIT_STATES+2.
// Backpressure: stall_pipe holds the whole pipeline for a pending data access, stall_fetch holds PC/IF-ID.
// Ports: if_* fetch side, mem_* load/store side, ram_* RAM side, stall_* into the hazard enables.
// Optional macro MEMORY_ARBITER_FAIRNESS_EN: after a data grant, a contending fetch wins the next grant.
module memory_port_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ready,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    output logic                  ram_re,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  stall_fetch,
    output logic                  stall_pipe
);

    localparam int             CW      = cnt_width(WAIT_STATES);
    localparam logic [CW-1:0]  WS_LOAD = CW'(WAIT_STATES);

    arb_state_t            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  we_q;
    logic                  done_if;
    logic [DATA_WIDTH-1:0] if_rdata_q;
    logic [DATA_WIDTH-1:0] mem_rdata_q;

    logic [CW-1:0] cnt;
    logic          cnt_zero;
    logic          data_pend;
    logic          fetch_pend;
    logic          grant_fetch;
    logic          grant_data;
    logic          load;
    logic          fetch_done;
    logic          data_done;

    assign data_pend  = mem_read | mem_write;
    // A held fetch result must be consumed before the next fetch may start.
    assign fetch_pend = if_req & ~done_if;

`ifdef MEMORY_ARBITER_FAIRNESS_EN
    logic last_grant;

    assign grant_fetch = fetch_pend & (~data_pend | (last_grant == GNT_DATA));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= GNT_FETCH;
        end else if (load) begin
            last_grant <= grant_data ? GNT_DATA : GNT_FETCH;
        end
    end
`else
    assign grant_fetch = fetch_pend & ~data_pend;
`endif

    assign grant_data = data_pend & ~grant_fetch;
    assign load       = (state == IDLE) & (grant_data | grant_fetch);

    wait_state_counter #(
        .WAIT_STATES (WAIT_STATES)
    ) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .value (WS_LOAD),
        .count (cnt),
        .zero  (cnt_zero)
    );

    // The counter sits at zero in IDLE, so zero only marks a final cycle inside an access.
    assign fetch_done = (state == FETCH) & cnt_zero;
    assign data_done  = (state == DATA)  & cnt_zero;

    assign ram_addr    = addr_q;
    assign ram_wdata   = wdata_q;
    assign ram_re      = (state != IDLE);
    assign ram_we      = data_done & we_q;
    assign if_ready    = fetch_done | done_if;
    assign mem_ready   = data_done;
    assign if_rdata    = fetch_done ? ram_rdata : if_rdata_q;
    assign mem_rdata   = (data_done & ~we_q) ? ram_rdata : mem_rdata_q;
    assign stall_pipe  = data_pend & ~mem_ready;
    assign stall_fetch = stall_pipe | (if_req & ~if_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            done_if     <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state   <= grant_data ? DATA : FETCH;
                        addr_q  <= grant_data ? mem_addr : if_addr;
                        wdata_q <= mem_wdata;
                        // Read and write together is a store.
                        we_q    <= grant_data & mem_write;
                    end
                end
                FETCH, DATA: begin
                    if (cnt_zero) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // The fetch result stays visible until a cycle where the pipeline actually advances.
            done_if <= if_ready & stall_pipe;

            if (fetch_done) begin
                if_rdata_q <= ram_rdata;
            end
            if (data_done & ~we_q) begin
                mem_rdata_q <= ram_rdata;
            end
        end
    end

    idle_cnt_zero: assert property (@(posedge clk) disable iff (!reset) (state == IDLE) |-> (cnt == '0));

endmodule
